// File: rtl/key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : key_schedule
//  Description : Sequential AES-128 key expansion. Loads a cipher key as
//                round 0, then produces one registered round key per
//                accepted advance request (rounds 0..10).
//                Optional macro KEY_SCHEDULE_INV_EN adds backward stepping
//                (rev=1) for the decryption path.
//  Revision    : 1.0  initial release
// ============================================================================
module key_schedule (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         next,
    input  logic         rev,
    output logic [127:0] round_key,
    output logic [3:0]   round,
    output logic         valid,
    output logic         last
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_READY = 1'b1;

    localparam logic [3:0] c_LAST_ROUND = 4'd10;
    localparam logic [7:0] c_RCON_INIT  = 8'h01;

    // FIPS-197 forward S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return c_SBOX[{~x, 3'b000} +: 8];
    endfunction

    logic [0:0]   r_state;
    logic [0:0]   w_state_nxt;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic         r_last;
    logic [7:0]   r_rcon;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_sub_in, w_rot, w_sub, w_t;
    logic [31:0]  w_f0, w_f1, w_f2, w_f3;
    logic [7:0]   w_rcon_fwd;
    logic         w_accept, w_fwd;

    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];

    // start has priority over next, and next is only meaningful once loaded
    assign w_accept = (r_state == c_READY) && next && !start;

`ifdef KEY_SCHEDULE_INV_EN
    logic         w_bwd;
    logic [31:0]  w_b0, w_b1, w_b2, w_b3;
    logic [7:0]   w_rcon_prev;

    assign w_fwd = w_accept && !rev && (r_round < c_LAST_ROUND);
    assign w_bwd = w_accept &&  rev && (r_round != 4'd0);

    // r_rcon holds the constant for the next forward step, so the one that
    // produced the current round is its inverse-xtime
    assign w_rcon_prev = r_rcon[0] ? ({1'b0, r_rcon[7:1]} ^ 8'h8d)
                                   :  {1'b0, r_rcon[7:1]};

    // backward recovers w3 of the previous round first; the shared S-boxes
    // then act on it instead of the current w3
    assign w_b3     = w_w3 ^ w_w2;
    assign w_b2     = w_w2 ^ w_w1;
    assign w_b1     = w_w1 ^ w_w0;
    assign w_sub_in = w_bwd ? w_b3 : w_w3;
    assign w_b0     = w_w0 ^ w_sub ^ {w_rcon_prev, 24'h0};
`else
    logic w_unused_rev;
    assign w_unused_rev = rev;
    assign w_fwd        = w_accept && (r_round < c_LAST_ROUND);
    assign w_sub_in     = w_w3;
`endif

    assign w_rot = {w_sub_in[23:0], w_sub_in[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign w_sub[8*gi +: 8] = sbox(w_rot[8*gi +: 8]);
        end
    endgenerate

    assign w_t  = w_sub ^ {r_rcon, 24'h0};
    assign w_f0 = w_w0 ^ w_t;
    assign w_f1 = w_w1 ^ w_f0;
    assign w_f2 = w_w2 ^ w_f1;
    assign w_f3 = w_w3 ^ w_f2;

    assign w_rcon_fwd = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    // state register: IDLE until the first start, READY thereafter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_nxt;
    end

    // next-state: only start moves the FSM, only reset brings it back
    always_comb begin
        w_state_nxt = r_state;
        if (start) w_state_nxt = c_READY;
    end

    // round key, round counter, last flag and RCON update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key   <= 128'h0;
            r_round <= 4'd0;
            r_last  <= 1'b0;
            r_rcon  <= c_RCON_INIT;
        end else if (start) begin
            r_key   <= key;
            r_round <= 4'd0;
            r_last  <= 1'b0;
            r_rcon  <= c_RCON_INIT;
        end else if (w_fwd) begin
            r_key   <= {w_f0, w_f1, w_f2, w_f3};
            r_round <= r_round + 4'd1;
            r_last  <= (r_round == c_LAST_ROUND - 4'd1);
            r_rcon  <= w_rcon_fwd;
`ifdef KEY_SCHEDULE_INV_EN
        end else if (w_bwd) begin
            r_key   <= {w_b0, w_b1, w_b2, w_b3};
            r_round <= r_round - 4'd1;
            r_last  <= 1'b0;
            r_rcon  <= w_rcon_prev;
`endif
        end
    end

    assign round_key = r_key;
    assign round     = r_round;
    assign valid     = (r_state == c_READY);
    assign last      = r_last;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_schedule
//  Description : Self-checking bench for key_schedule. A reference model
//                expands the whole key with the textbook recurrence (S-box
//                derived from GF(2^8) inversion) and tracks the round index.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_schedule;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic         next;
    logic         rev;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic         valid;
    logic         last;

    int errors = 0;
    int checks = 0;

    key_schedule dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key       (key),
        .next      (next),
        .rev       (rev),
        .round_key (round_key),
        .round     (round),
        .valid     (valid),
        .last      (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  m_sbox [256];
    logic [31:0] m_w    [44];
    logic        m_valid;
    int          m_round;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic void build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h0;
            for (int c = 1; c < 256; c++)
                if (x != 0 && gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            m_sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endfunction

    function automatic void expand(input logic [127:0] k);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) m_w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = m_w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = xt(rc);
            end
            m_w[i] = m_w[i-4] ^ t;
        end
    endfunction

    function automatic void model_step(input logic s, input logic n, input logic rv,
                                       input logic [127:0] k);
        if (s) begin
            m_valid = 1'b1;
            m_round = 0;
            expand(k);
        end else if (n && m_valid) begin
`ifdef KEY_SCHEDULE_INV_EN
            if (rv) begin
                if (m_round > 0) m_round = m_round - 1;
            end else if (m_round < 10) m_round = m_round + 1;
`else
            if (rv || !rv) begin
                if (m_round < 10) m_round = m_round + 1;
            end
`endif
        end
    endfunction

    function automatic logic [127:0] exp_key();
        if (!m_valid) return 128'h0;
        return {m_w[4*m_round], m_w[4*m_round+1], m_w[4*m_round+2], m_w[4*m_round+3]};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".round_key"}, round_key, exp_key());
        chk({tag, ".round"}, {124'h0, round}, 128'(m_round));
        chk({tag, ".valid"}, {127'h0, valid}, {127'h0, m_valid});
        chk({tag, ".last"}, {127'h0, last}, {127'h0, (m_valid && m_round == 10)});
    endtask

    // one clock with the given inputs held across the edge
    task automatic cycle(input logic s, input logic n, input logic rv, input logic [127:0] k);
        start = s; next = n; rev = rv; key = k;
        @(posedge clk);
        #1;
        model_step(s, n, rv, k);
        start = 1'b0; next = 1'b0; rev = 1'b0;
    endtask

    logic [127:0] fips_key;
    logic [127:0] rnd_key;
    logic         rs, rn, rr;

    initial begin
        fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        build_sbox();
        m_valid = 1'b0;
        m_round = 0;
        start = 1'b0; next = 1'b0; rev = 1'b0; key = 128'h0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_all("reset");

        // next while IDLE is ignored
        cycle(1'b0, 1'b1, 1'b0, fips_key);
        check_all("idle_next");

        // load FIPS-197 A.1 key
        cycle(1'b1, 1'b0, 1'b0, fips_key);
        check_all("load");
        chk("load.const", round_key, fips_key);

        cycle(1'b0, 1'b1, 1'b0, 128'h0);
        check_all("step1");
        chk("step1.const", round_key, 128'ha0fafe1788542cb123a339392a6c7605);

        for (int i = 2; i <= 10; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 128'h0);
            check_all("fwd");
        end
        chk("r10.const", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("r10.last", {127'h0, last}, 128'h1);

        // forward next at round 10 holds everything
        cycle(1'b0, 1'b1, 1'b0, 128'h0);
        check_all("fwd_past10");
        chk("hold.const", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef KEY_SCHEDULE_INV_EN
        for (int i = 9; i >= 0; i--) begin
            cycle(1'b0, 1'b1, 1'b1, 128'h0);
            check_all("bwd");
            if (i == 1) chk("bwd1.const", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
        end
        chk("bwd0.const", round_key, fips_key);
        cycle(1'b0, 1'b1, 1'b1, 128'h0);
        check_all("bwd_past0");
        chk("bwd_hold.const", round_key, fips_key);
`else
        // rev is meaningless here; at round 10 this is a forward no-op
        cycle(1'b0, 1'b1, 1'b1, 128'h0);
        check_all("rev_ignored");
`endif

        // start and next together at round 5: start wins
        cycle(1'b1, 1'b0, 1'b0, fips_key);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 128'h0);
        check_all("round5");
        rnd_key = {$urandom, $urandom, $urandom, $urandom};
        cycle(1'b1, 1'b1, 1'b0, rnd_key);
        check_all("start_wins");
        chk("start_wins.const", round_key, rnd_key);

        // asynchronous reset mid-cycle, no clock edge involved
        #2 reset = 1'b1;
        #1;
        m_valid = 1'b0;
        m_round = 0;
        check_all("async_reset");
        #1 reset = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(0, 15) == 0);
            rn = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) == 0);
            rnd_key = {$urandom, $urandom, $urandom, $urandom};
            cycle(rs, rn, rr, rnd_key);
            check_all("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_schedule.md
# key_schedule

Sequential AES-128 key expansion unit that produces the round keys consumed by the round-key XOR stage of the cipher datapath. It loads a 128-bit cipher key, then generates one 128-bit round key per advance request (rounds 0..10, one cycle each) and presents it on a registered output. It also tracks the round counter and RCON state. The cipher FSM drives it with `start`/`next` and reads `round_key` directly.

## Interface
- No parameters; fixed to AES-128 (Nk=4, Nr=10).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle pulse; load `key` as round 0.
- `key`  in  128  cipher key, sampled only when `start`=1; bits [127:96] = w0.
- `next`  in  1  advance one round; honoured only when `valid`=1.
- `rev`  in  1  direction qualifier for `next` (0 = forward, 1 = backward); used only when `KEY_SCHEDULE_INV_EN` is defined.
- `round_key`  out  128  current round key {w4i, w4i+1, w4i+2, w4i+3}, registered.
- `round`  out  4  index of `round_key`, 0..10.
- `valid`  out  1  `round_key`/`round` hold a legal key.
- `last`  out  1  `round`==10.

## Operation
- States: IDLE (valid=0) and READY (valid=1). IDLE→READY on `start`. READY stays READY; `start` in READY reloads. No return to IDLE except by reset.
- Reset values: `round_key`=0, `round`=0, `valid`=0, `last`=0, internal RCON=0x01.
- Start: `round_key`←`key`, `round`←0, RCON←0x01.
- Forward step (`next`=1, `rev`=0, `round`<10):
  - t = SubWord(RotWord(w3)) ^ {RCON,24'h0}, with RotWord(x) = {x[23:0],x[31:24]} and SubWord = FIPS-197 S-box per byte.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - `round`+1; RCON←xtime(RCON), i.e. 01,02,04,08,10,20,40,80,1B,36.
- Forward `next` at `round`=10: ignored; all outputs hold.
- `next` while `valid`=0: ignored.
- Simultaneous `start` and `next`: `start` wins.
- The S-box is an internal combinational lookup (4 instances, one per byte of w3). No external memory.

## Timing
- `start` sampled at edge N → `round_key`=`key`, `round`=0, `valid`=1 after edge N.
- Each accepted `next` updates `round_key`/`round`/`last` after the same edge. This gives 1-cycle latency and allows back-to-back `next` every cycle.
- Full forward schedule: `start` plus 10 consecutive `next` = 11 edges; `last`=1 after the 11th.
- Outputs change only on accepted `start`/`next` or reset; they are stable otherwise.
- `reset` asserted mid-schedule clears outputs immediately (asynchronously). The first `start` after deassertion behaves as from power-up.

## Configuration
- `KEY_SCHEDULE_INV_EN` defined:
  - `next` with `rev`=1 and `round`>0 steps backward one round, with 1-cycle latency.
  - Backward step: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^{RCON_prev,24'h0}.
  - RCON_prev is the RCON used to derive the current round; the RCON register steps backward (inverse xtime sequence).
  - `rev`=1 at `round`=0 is ignored.
  - This serves the decryption path: run forward to round 10, then walk back.
- Not defined:
  - `rev` is ignored and `next` always steps forward.
  - No backward logic or inverse RCON logic is synthesised.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → `round_key`=0, `round`=0, `valid`=0, `last`=0 without waiting for a clock edge.
- FIPS-197 A.1 load: `start`, `key`=2b7e151628aed2a6abf7158809cf4f3c → next cycle `round_key`=key, `round`=0, `valid`=1.
- First step: one `next` → `round_key`=a0fafe1788542cb123a339392a6c7605, `round`=1.
- Full run: 10 back-to-back `next` → `round_key`=d014f9a8c9ee2589e13f0cc8b6630ca6, `last`=1. An 11th `next` leaves all outputs unchanged.
- Contention: `next` in IDLE → no change. `start` and `next` together at round 5 → `round`=0, `round_key`=`key`.
- With `KEY_SCHEDULE_INV_EN`: from round 10, 10 `next` with `rev`=1 → `round_key` steps back to a0fafe17… at round 1, then 2b7e1516… at round 0. A further `rev` step is ignored.
